// File: rtl/integration_s4pu_sequencer_pkg.sv
// Register map, bit positions, state encodings and command decode shared by the
// sequencer RTL, the firmware header generator and the bench.
package integration_s4pu_sequencer_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STAT   = 2'd1;
  localparam logic [1:0] ADDR_STEP_N = 2'd2;
  localparam logic [1:0] ADDR_CYCLES = 2'd3;

  localparam int CTRL_SOFT_RST = 0;
  localparam int CTRL_RUN      = 1;
  localparam int CTRL_STEP     = 2;
  localparam int CTRL_STOP     = 3;
  localparam int CTRL_IRQ_EN   = 4;

  localparam int STAT_HALTED   = 3;
  localparam int STAT_IRQ_PEND = 4;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_RUN    = 3'd2,
    ST_STEP   = 3'd3,
    ST_HALTED = 3'd4
  } seq_state_t;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_SOFT_RST,
    CMD_STOP,
    CMD_STEP,
    CMD_RUN
  } seq_cmd_t;

  // Only the highest-priority command of a CTRL write is acted on.
  function automatic seq_cmd_t decode_cmd(input logic [3:0] bits);
    if (bits[CTRL_SOFT_RST])  return CMD_SOFT_RST;
    else if (bits[CTRL_STOP]) return CMD_STOP;
    else if (bits[CTRL_STEP]) return CMD_STEP;
    else if (bits[CTRL_RUN])  return CMD_RUN;
    else                      return CMD_NONE;
  endfunction

endpackage

// File: rtl/integration_s4pu_sequencer_if.sv
// Avalon-MM slave bus of the sequencer: zero-wait-state writes, combinational reads.
// No backpressure: every chipselect access completes in the cycle it is presented.
interface integration_s4pu_sequencer_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/integration_s4pu_step_counter.sv
// Loadable down-counter for the STEP burst length; flags the final enabled cycle.
// Load/decrement take effect on the next clk edge; no backpressure.
module integration_s4pu_step_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         is_one
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec)  cnt <= cnt - W'(1);
  end

  assign is_one = (cnt == W'(1));

endmodule

// File: rtl/integration_s4pu_sequencer.sv
// S4PU core sequencer: reset hold, free run, N-cycle step, halt capture, cycle count, IRQ.
// CTRL write in T moves the FSM at the end of T, core pins follow in T+1; bus never stalls.
module integration_s4pu_sequencer
  import integration_s4pu_sequencer_pkg::*;
#(
  parameter int RST_HOLD = 4,
  parameter int STEP_W   = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  integration_s4pu_sequencer_if.slave   bus,
  input  logic                          s4pu_halt,
  output logic                          s4pu_rst,
  output logic                          s4pu_en,
  output logic                          irq
);

  localparam int HOLD_W = (RST_HOLD < 2) ? 1 : $clog2(RST_HOLD + 1);

  seq_state_t        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              halted_sticky;
  logic              irq_pend;
  logic              irq_en;
  logic [STEP_W-1:0] step_n;
  logic [31:0]       cycles;

  logic     bus_wr, ctrl_wr, stat_wr, step_wr, cyc_wr;
  seq_cmd_t cmd;
  logic     core_on, halt_hit, step_last, step_done, step_load, step_dec;
  logic     unused_wdata;

  assign bus_wr  = bus.chipselect & ~bus.write_n;
  assign ctrl_wr = bus_wr && (bus.address == ADDR_CTRL);
  assign stat_wr = bus_wr && (bus.address == ADDR_STAT);
  assign step_wr = bus_wr && (bus.address == ADDR_STEP_N);
  assign cyc_wr  = bus_wr && (bus.address == ADDR_CYCLES);
  assign cmd     = ctrl_wr ? decode_cmd(bus.writedata[3:0]) : CMD_NONE;
  assign unused_wdata = ^bus.writedata;

  // Halt beats STOP; SOFT_RST beats everything.
  assign core_on   = (state == ST_RUN) || (state == ST_STEP);
  assign halt_hit  = core_on && s4pu_halt && (cmd != CMD_SOFT_RST);
  assign step_done = (state == ST_STEP) && !s4pu_halt && (cmd != CMD_SOFT_RST)
                     && (cmd != CMD_STOP) && step_last;
  assign step_dec  = (state == ST_STEP) && !s4pu_halt && (cmd != CMD_SOFT_RST)
                     && (cmd != CMD_STOP) && !step_last;
  assign step_load = (state == ST_IDLE) && (cmd == CMD_STEP) && (step_n != '0);

  integration_s4pu_step_counter #(.W(STEP_W)) u_step_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (step_load),
    .load_val (step_n),
    .dec      (step_dec),
    .is_one   (step_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_RESET;
      hold_cnt      <= HOLD_W'(RST_HOLD);
      s4pu_rst      <= 1'b1;
      s4pu_en       <= 1'b0;
      halted_sticky <= 1'b0;
    end else if (cmd == CMD_SOFT_RST) begin
      state         <= ST_RESET;
      hold_cnt      <= HOLD_W'(RST_HOLD);
      s4pu_rst      <= 1'b1;
      s4pu_en       <= 1'b0;
      halted_sticky <= 1'b0;
    end else begin
      case (state)
        ST_RESET: begin
          if (hold_cnt == HOLD_W'(1)) begin
            state    <= ST_IDLE;
            s4pu_rst <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        ST_IDLE: begin
          if (step_load) begin
            state   <= ST_STEP;
            s4pu_en <= 1'b1;
          end else if (cmd == CMD_RUN) begin
            state   <= ST_RUN;
            s4pu_en <= 1'b1;
          end
        end
        ST_RUN, ST_STEP: begin
          if (halt_hit) begin
            state         <= ST_HALTED;
            s4pu_en       <= 1'b0;
            halted_sticky <= 1'b1;
          end else if (cmd == CMD_STOP || step_done) begin
            state   <= ST_IDLE;
            s4pu_en <= 1'b0;
          end
        end
        ST_HALTED: ;
        default: begin
          state    <= ST_RESET;
          hold_cnt <= HOLD_W'(RST_HOLD);
          s4pu_rst <= 1'b1;
          s4pu_en  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en   <= 1'b0;
      irq_pend <= 1'b0;
      step_n   <= STEP_W'(1);
      cycles   <= '0;
    end else begin
      if (ctrl_wr) irq_en <= bus.writedata[CTRL_IRQ_EN];
      // A new event wins over a simultaneous write-one-to-clear.
      if (halt_hit || step_done)                   irq_pend <= 1'b1;
      else if (stat_wr && bus.writedata[STAT_IRQ_PEND]) irq_pend <= 1'b0;
      if (step_wr) step_n <= bus.writedata[STEP_W-1:0];
      if (cyc_wr)       cycles <= '0;
      else if (s4pu_en) cycles <= cycles + 32'd1;
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_CTRL:   bus.readdata[CTRL_IRQ_EN] = irq_en;
      ADDR_STAT:   bus.readdata[4:0] = {irq_pend, halted_sticky, state};
      ADDR_STEP_N: bus.readdata[STEP_W-1:0] = step_n;
      default:     bus.readdata = cycles;
    endcase
  end

  assign irq = irq_pend & irq_en;

endmodule

// File: tb/tb_integration_s4pu_sequencer.sv
// Directed bench for the S4PU sequencer: reset hold, stepping, halt, command priority, IRQ.
module tb_integration_s4pu_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic s4pu_halt = 1'b0;
  logic s4pu_rst, s4pu_en, irq;
  int   checks = 0;
  int   errors = 0;

  integration_s4pu_sequencer_if bus ();

  integration_s4pu_sequencer #(.RST_HOLD(4), .STEP_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .s4pu_halt (s4pu_halt),
    .s4pu_rst  (s4pu_rst),
    .s4pu_en   (s4pu_en),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Presents a write for one cycle; call #1 after a rising edge, returns #1 after the next.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #1;
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] d;
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk);
      #1;
      rd(2'd1, d);
      if (d[2:0] == 3'd1) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: state %0d never reached IDLE (1)", name, d[2:0]);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int n = 0;
    repeat (2) @(posedge clk);
    #1;
    rd(2'd1, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_stat: got %h want 0", d); end
    checks++;
    if ({s4pu_rst, s4pu_en, irq} !== 3'b100) begin
      errors++; $display("FAIL reset_pins: rst/en/irq=%b want 100", {s4pu_rst, s4pu_en, irq});
    end
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (s4pu_rst) n++;
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL reset_hold: rst high %0d cycles want 4", n); end
    rd(2'd1, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL reset_idle: stat %h want 1", d); end
    rd(2'd3, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_cycles: got %0d want 0", d); end
  endtask

  task automatic test_step();
    logic [31:0] d;
    int n = 0;
    @(posedge clk); #1;
    wr(2'd2, 32'd5);
    wr(2'd0, 32'h04);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (s4pu_en) n++;
    end
    checks++;
    if (n != 5) begin errors++; $display("FAIL step_len: en high %0d cycles want 5", n); end
    rd(2'd1, d);
    checks++;
    if (d !== 32'h11) begin errors++; $display("FAIL step_stat: got %h want 11", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL step_irq_masked: irq=%b want 0", irq); end
    @(posedge clk); #1;
    wr(2'd0, 32'h10);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL step_irq_en: irq=%b want 1", irq); end
    rd(2'd0, d);
    checks++;
    if (d !== 32'h10) begin errors++; $display("FAIL ctrl_read: got %h want 10", d); end
    rd(2'd3, d);
    checks++;
    if (d !== 32'd5) begin errors++; $display("FAIL step_cycles: got %0d want 5", d); end
    @(posedge clk); #1;
    wr(2'd1, 32'h10);
    wr(2'd3, 32'h0);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq: irq=%b want 0", irq); end
    rd(2'd3, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL cycles_clear: got %0d want 0", d); end
  endtask

  task automatic test_run_halt();
    logic [31:0] d;
    @(posedge clk); #1;
    wr(2'd0, 32'h12);
    repeat (9) @(posedge clk);
    #1;
    s4pu_halt = 1'b1;
    @(posedge clk);
    #1;
    s4pu_halt = 1'b0;
    checks++;
    if (s4pu_en !== 1'b0) begin errors++; $display("FAIL halt_en: en=%b want 0", s4pu_en); end
    rd(2'd1, d);
    checks++;
    if (d !== 32'h1C) begin errors++; $display("FAIL halt_stat: got %h want 1c", d); end
    rd(2'd3, d);
    checks++;
    if (d !== 32'd10) begin errors++; $display("FAIL halt_cycles: got %0d want 10", d); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL halt_irq: irq=%b want 1", irq); end
    @(posedge clk); #1;
    wr(2'd0, 32'h12);
    repeat (3) @(posedge clk);
    #1;
    rd(2'd1, d);
    checks++;
    if (d[2:0] !== 3'd4 || s4pu_en !== 1'b0) begin
      errors++; $display("FAIL halt_run_ignored: state %0d en %b want 4 0", d[2:0], s4pu_en);
    end
  endtask

  task automatic test_halt_vs_stop();
    logic [31:0] d;
    int n = 0;
    @(posedge clk); #1;
    wr(2'd0, 32'h01);
    wait_idle("soft_rst_from_halted");
    wr(2'd0, 32'h02);
    s4pu_halt = 1'b1;
    wr(2'd0, 32'h08);
    s4pu_halt = 1'b0;
    rd(2'd1, d);
    checks++;
    if (d[3:0] !== 4'hC || s4pu_en !== 1'b0) begin
      errors++; $display("FAIL halt_beats_stop: stat %h en %b want c 0", d[3:0], s4pu_en);
    end
    @(posedge clk); #1;
    wr(2'd0, 32'h01);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s4pu_rst) n++;
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL soft_rst_hold: rst high %0d cycles want 4", n); end
    rd(2'd1, d);
    checks++;
    if (d[3:0] !== 4'h1) begin errors++; $display("FAIL soft_rst_idle: stat %h want 1", d[3:0]); end
  endtask

  task automatic test_zero_step_priority();
    logic [31:0] d;
    int n = 0;
    @(posedge clk); #1;
    wr(2'd2, 32'd0);
    wr(2'd0, 32'h04);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s4pu_en) n++;
    end
    rd(2'd1, d);
    checks++;
    if (n != 0 || d[2:0] !== 3'd1) begin
      errors++; $display("FAIL step_zero: en cycles %0d state %0d want 0 1", n, d[2:0]);
    end
    @(posedge clk); #1;
    wr(2'd0, 32'h0F);
    rd(2'd1, d);
    checks++;
    if (d[2:0] !== 3'd0 || s4pu_rst !== 1'b1 || s4pu_en !== 1'b0) begin
      errors++; $display("FAIL cmd_priority: state %0d rst %b en %b want 0 1 0", d[2:0], s4pu_rst, s4pu_en);
    end
    wait_idle("after_priority");
  endtask

  task automatic test_irq_race_and_reset();
    logic [31:0] d;
    @(posedge clk); #1;
    wr(2'd1, 32'h10);
    rd(2'd1, d);
    checks++;
    if (d[4] !== 1'b0) begin errors++; $display("FAIL pend_clear: pend=%b want 0", d[4]); end
    @(posedge clk); #1;
    wr(2'd2, 32'd1);
    wr(2'd0, 32'h14);
    wr(2'd1, 32'h10);
    rd(2'd1, d);
    checks++;
    if (d !== 32'h11) begin errors++; $display("FAIL set_beats_w1c: stat %h want 11", d); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL race_irq: irq=%b want 1", irq); end
    @(posedge clk); #1;
    wr(2'd2, 32'd100);
    wr(2'd0, 32'h14);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (s4pu_en !== 1'b1) begin errors++; $display("FAIL mid_step_en: en=%b want 1", s4pu_en); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({s4pu_rst, s4pu_en, irq} !== 3'b100) begin
      errors++; $display("FAIL async_pins: rst/en/irq=%b want 100", {s4pu_rst, s4pu_en, irq});
    end
    rd(2'd1, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL async_stat: got %h want 0", d); end
    rd(2'd2, d);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL async_step_n: got %0d want 1", d); end
    rd(2'd3, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL async_cycles: got %0d want 0", d); end
    rd(2'd0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL async_ctrl: got %h want 0", d); end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    test_reset();
    test_step();
    test_run_halt();
    test_halt_vs_stop();
    test_zero_step_priority();
    test_irq_race_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
